// File: rtl/phys_reg_free_list_pkg.sv
// Constants and types shared by the rename free list and the physical register file.
package phys_reg_free_list_pkg;
  localparam int PREG_W     = 5;
  localparam int PHYS_REGS  = 32;
  localparam int FREE_DEPTH = 30;
  localparam logic [PREG_W-1:0] PREG_ZERO = 5'd0;
  localparam logic [PREG_W-1:0] PREG_ONE  = 5'd1;

  typedef logic [PREG_W-1:0] preg_t;

  // Indices 0 and 1 are hardwired and must never enter the free list.
  function automatic logic is_allocatable(input preg_t p);
    return (p != PREG_ZERO) && (p != PREG_ONE);
  endfunction
endpackage

// File: rtl/ring_idx_add.sv
// (index + offset) mod FREE_DEPTH for the free-list ring; index < depth, offset <= depth.
module ring_idx_add
  import phys_reg_free_list_pkg::*;
(
  input  preg_t              idx,
  input  logic [PREG_W-1:0]  off,
  output preg_t              sum
);
  logic [PREG_W:0] raw;

  always_comb begin
    raw = {1'b0, idx} + {1'b0, off};
    sum = (raw >= (PREG_W+1)'(FREE_DEPTH)) ? preg_t'(raw - (PREG_W+1)'(FREE_DEPTH))
                                           : raw[PREG_W-1:0];
  end
endmodule

// File: rtl/phys_reg_free_list.sv
// Multi-lane physical register free list with one head checkpoint for speculative rollback.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
#(
  parameter int ALLOC_W   = 2,
  parameter int FREE_W    = 2,
  parameter int ARCH_REGS = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ALLOC_W-1:0]        alloc_req,
  output logic                      alloc_ok,
  output logic [PREG_W*ALLOC_W-1:0] alloc_addrs,
  input  logic [FREE_W-1:0]         free_valid,
  input  logic [PREG_W*FREE_W-1:0]  free_addrs,
  input  logic                      ckpt_take,
  input  logic                      ckpt_restore,
  output logic [PREG_W-1:0]         free_count,
  output logic                      overflow_err
);
  localparam int INIT_CNT = FREE_DEPTH - ARCH_REGS;
  localparam logic [PREG_W:0] DEPTH_C = (PREG_W+1)'(FREE_DEPTH);

  preg_t             mem_q [FREE_DEPTH];
  preg_t             head_q, head_d, tail_q, tail_d;
  preg_t             ckpt_head_q, ckpt_head_d;
  logic [PREG_W-1:0] count_q, count_d, ckpt_cnt_q, ckpt_cnt_d;
  logic              overflow_q, overflow_d;

  logic [PREG_W-1:0] alloc_pre [ALLOC_W+1];
  logic [PREG_W-1:0] free_pre  [FREE_W+1];
  preg_t             alloc_idx [ALLOC_W];
  preg_t             push_idx  [FREE_W];
  logic [FREE_W-1:0] push_en;
  logic [PREG_W-1:0] popped;
  preg_t             head_adv, tail_adv;
  logic [PREG_W:0]   base_cnt, room;
  logic              drop;

  // Prefix popcount compacts requesting lanes onto consecutive ring entries.
  always_comb begin
    alloc_pre[0] = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_pre[i+1] = alloc_pre[i] + PREG_W'(alloc_req[i]);
    end
    alloc_ok = (alloc_pre[ALLOC_W] <= count_q) && !ckpt_restore;
    popped   = alloc_ok ? alloc_pre[ALLOC_W] : '0;
  end

  // Releases fill remaining room in lane order, so the highest lanes drop first.
  always_comb begin
    base_cnt    = ckpt_restore ? ({1'b0, count_q} + {1'b0, ckpt_cnt_q})
                               : ({1'b0, count_q} - {1'b0, popped});
    room        = (base_cnt >= DEPTH_C) ? '0 : DEPTH_C - base_cnt;
    free_pre[0] = '0;
    push_en     = '0;
    drop        = 1'b0;
    for (int i = 0; i < FREE_W; i++) begin
      if (free_valid[i] && is_allocatable(free_addrs[PREG_W*i +: PREG_W])) begin
        if ({1'b0, free_pre[i]} < room) push_en[i] = 1'b1;
        else                            drop       = 1'b1;
      end
      free_pre[i+1] = free_pre[i] + PREG_W'(push_en[i]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ALLOC_W; gi++) begin : g_alloc
      ring_idx_add u_add (.idx(head_q), .off(alloc_pre[gi]), .sum(alloc_idx[gi]));
      assign alloc_addrs[PREG_W*gi +: PREG_W] = mem_q[alloc_idx[gi]];
    end
    for (gi = 0; gi < FREE_W; gi++) begin : g_free
      ring_idx_add u_add (.idx(tail_q), .off(free_pre[gi]), .sum(push_idx[gi]));
    end
  endgenerate

  ring_idx_add u_head (.idx(head_q), .off(popped),           .sum(head_adv));
  ring_idx_add u_tail (.idx(tail_q), .off(free_pre[FREE_W]), .sum(tail_adv));

  always_comb begin
    head_d      = head_adv;
    tail_d      = tail_adv;
    count_d     = PREG_W'(base_cnt + {1'b0, free_pre[FREE_W]});
    ckpt_head_d = ckpt_head_q;
    ckpt_cnt_d  = ckpt_cnt_q;
    overflow_d  = overflow_q | drop;
    if (ckpt_restore) begin
      // Snapshot stays put, so a same-cycle take is equivalent to keeping it.
      head_d     = ckpt_head_q;
      ckpt_cnt_d = '0;
    end else if (ckpt_take) begin
      ckpt_head_d = head_adv;
      ckpt_cnt_d  = '0;
    end else begin
      ckpt_cnt_d = ckpt_cnt_q + popped;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < FREE_DEPTH; k++) begin
        mem_q[k] <= (k < INIT_CNT) ? PREG_W'(2 + ARCH_REGS + k) : '0;
      end
      head_q      <= '0;
      tail_q      <= PREG_W'(INIT_CNT);
      count_q     <= PREG_W'(INIT_CNT);
      ckpt_head_q <= '0;
      ckpt_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      for (int i = 0; i < FREE_W; i++) begin
        if (push_en[i]) mem_q[push_idx[i]] <= free_addrs[PREG_W*i +: PREG_W];
      end
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ckpt_head_q <= ckpt_head_d;
      ckpt_cnt_q  <= ckpt_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign free_count   = count_q;
  assign overflow_err = overflow_q;
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed and randomized bench for phys_reg_free_list against a queue-based model.
module tb_phys_reg_free_list;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] alloc_req = '0;
  logic       alloc_ok;
  logic [9:0] alloc_addrs;
  logic [1:0] free_valid = '0;
  logic [9:0] free_addrs = '0;
  logic       ckpt_take = 1'b0;
  logic       ckpt_restore = 1'b0;
  logic [4:0] free_count;
  logic       overflow_err;

  int checks = 0;
  int failures = 0;

  // Model: fl = free indices in allocation order, spec = allocated since the
  // checkpoint (oldest first), outp = committed mappings eligible for release.
  int fl[$];
  int spec[$];
  int outp[$];
  bit m_ovf;

  phys_reg_free_list dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_ok(alloc_ok),
    .alloc_addrs(alloc_addrs), .free_valid(free_valid), .free_addrs(free_addrs),
    .ckpt_take(ckpt_take), .ckpt_restore(ckpt_restore),
    .free_count(free_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fl.delete();
    spec.delete();
    outp.delete();
    for (int v = 8; v < 32; v++) fl.push_back(v);
    for (int v = 2; v < 8; v++) outp.push_back(v);
    m_ovf = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    alloc_req = '0;
    #1;
    chk({tag, "_count"}, free_count, 24);
    chk({tag, "_ok"}, alloc_ok, 1);
    chk({tag, "_lane0"}, alloc_addrs[4:0], 8);
    chk({tag, "_ovf"}, overflow_err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_req = '0; free_valid = '0; free_addrs = '0;
    ckpt_take = 1'b0; ckpt_restore = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_state("reset");
  endtask

  // One clock of stimulus; called just after a falling edge.
  task automatic step(input logic [1:0] req, input logic [1:0] fv, input logic [9:0] fa,
                      input bit take, input bit restore);
    int  n, k, base;
    bit  ok;
    alloc_req = req; free_valid = fv; free_addrs = fa;
    ckpt_take = take; ckpt_restore = restore;
    #1;
    n  = int'(req[0]) + int'(req[1]);
    ok = (n <= fl.size()) && !restore;
    chk("alloc_ok", alloc_ok, ok);
    if (ok) begin
      k = 0;
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          chk($sformatf("alloc_lane%0d", i), alloc_addrs[5*i +: 5], fl[k]);
          k++;
        end
      end
    end
    $display("step req=%b ok=%0b addrs=%0d,%0d free=%b/%0d,%0d take=%0b rst_ck=%0b",
             req, alloc_ok, alloc_addrs[4:0], alloc_addrs[9:5], fv, fa[4:0], fa[9:5],
             take, restore);
    @(posedge clk);
    if (ok) for (int i = 0; i < n; i++) spec.push_back(fl.pop_front());
    if (restore) begin
      fl = {spec, fl};
      spec.delete();
    end
    base = fl.size();
    for (int i = 0; i < 2; i++) begin
      if (fv[i] && fa[5*i +: 5] >= 2) begin
        if (base < 30) begin
          fl.push_back(int'(fa[5*i +: 5]));
          base++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (take && !restore) begin
      foreach (spec[j]) outp.push_back(spec[j]);
      spec.delete();
    end
    @(negedge clk);
    chk("free_count", free_count, fl.size());
    chk("overflow_err", overflow_err, m_ovf);
  endtask

  initial begin
    logic [1:0] fv;
    logic [9:0] fa;
    int j;

    do_reset();

    // Basic multi-lane allocation
    step(2'b11, 2'b00, 10'd0, 0, 0);
    step(2'b10, 2'b00, 10'd0, 0, 0);
    chk("tp_count21", free_count, 21);

    // Drain to one entry, then an unservable request with a same-cycle release
    for (int i = 0; i < 10; i++) step(2'b11, 2'b00, 10'd0, 0, 0);
    chk("tp_count1", free_count, 1);
    step(2'b11, 2'b01, {5'd0, 5'd9}, 0, 0);
    chk("tp_count2", free_count, 2);
    step(2'b11, 2'b00, 10'd0, 0, 0);
    chk("tp_count0", free_count, 0);
    step(2'b01, 2'b00, 10'd0, 0, 0);

    // Releases of hardwired indices are ignored and leave the tail in place
    step(2'b00, 2'b11, {5'd1, 5'd0}, 0, 0);
    chk("tp_ignore01", free_count, 0);
    step(2'b00, 2'b01, {5'd0, 5'd20}, 0, 0);
    step(2'b01, 2'b00, 10'd0, 0, 0);

    // Checkpoint / restore
    do_reset();
    step(2'b00, 2'b00, 10'd0, 1, 0);
    for (int i = 0; i < 3; i++) step(2'b01, 2'b00, 10'd0, 0, 0);
    chk("tp_ck_count21", free_count, 21);
    step(2'b01, 2'b00, 10'd0, 0, 1);
    chk("tp_ck_count24", free_count, 24);
    #1;
    chk("tp_ck_head8", alloc_addrs[4:0], 8);
    step(2'b01, 2'b00, 10'd0, 0, 0);

    // Overflow and asynchronous reset
    do_reset();
    step(2'b00, 2'b11, {5'd3, 5'd2}, 0, 0);
    step(2'b00, 2'b11, {5'd5, 5'd4}, 0, 0);
    step(2'b00, 2'b11, {5'd7, 5'd6}, 0, 0);
    chk("tp_full30", free_count, 30);
    step(2'b00, 2'b01, {5'd0, 5'd8}, 0, 0);
    chk("tp_ovf_count", free_count, 30);
    chk("tp_ovf_set", overflow_err, 1);
    step(2'b00, 2'b00, 10'd0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_count", free_count, 24);
    chk("async_ovf", overflow_err, 0);
    chk("async_lane0", alloc_addrs[4:0], 8);

    // Randomized traffic; releases come only from committed mappings
    do_reset();
    for (int c = 0; c < 500; c++) begin
      fv = '0;
      fa = '0;
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          fv[i] = 1'b1;
          fa[5*i +: 5] = 5'($urandom_range(0, 1));
        end else if (outp.size() > 0 && $urandom_range(0, 1) == 1) begin
          j = $urandom_range(0, outp.size() - 1);
          fv[i] = 1'b1;
          fa[5*i +: 5] = 5'(outp[j]);
          outp.delete(j);
        end
      end
      step(2'($urandom), fv, fa, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Free list of physical register indices for the out-of-order 6502 core. It produces the physical destination addresses that the rename stage assigns and that later drive the physical register file write ports. It takes back indices that commit releases. It supports one head checkpoint so the pipeline can roll back speculative allocations on a branch mispredict or flush.

## Interface
- ALLOC_W, 2, allocation lanes per cycle
- FREE_W, 2, release lanes per cycle
- ARCH_REGS, 6, physical regs 2..2+ARCH_REGS-1 start mapped to architectural state; not initially free
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- alloc_req  in  ALLOC_W  per-lane request for a new physical index
- alloc_ok  out  1  all requested lanes served this cycle (all-or-nothing)
- alloc_addrs  out  5*ALLOC_W  lane i index at [5*i +: 5]; meaningful only for requesting lanes when alloc_ok=1
- free_valid  in  FREE_W  per-lane release strobe
- free_addrs  in  5*FREE_W  released index, lane i at [5*i +: 5]
- ckpt_take  in  1  snapshot head position
- ckpt_restore  in  1  roll head back to snapshot
- free_count  out  5  entries currently free (0..30)
- overflow_err  out  1  sticky; a release was dropped because the list was full

## Operation
- Storage: circular buffer, 30 entries x 5 bits; head and tail indices mod 30; explicit 5-bit count.
- Indices 0 and 1 are hardwired constants (0x00 and 0x01). They are never allocated. free_valid lanes carrying 0 or 1 are ignored.
- Reset contents:
  - entry[k] = 2+ARCH_REGS+k for k < 30-ARCH_REGS.
  - head=0, tail=30-ARCH_REGS, count=30-ARCH_REGS (24 by default).
  - Checkpoint head=0, allocs-since-checkpoint=0, overflow_err=0.
- Allocation:
  - n = popcount(alloc_req).
  - alloc_ok = (n <= count) and not ckpt_restore.
  - Lane i receives entry[(head + number of requesting lanes below i) mod 30], so entries are compacted in lane order.
  - When alloc_ok=1, head += n. When alloc_ok=0, nothing is popped.
  - n=0 gives alloc_ok=1 with no effect.
- Release:
  - Valid lanes with address >= 2 are pushed at tail in lane order.
  - If count - popped + pushed would exceed 30, the excess lanes (highest lane first) are dropped and overflow_err is set.
  - Duplicate releases are not detected.
- Simultaneous alloc and release: count_next = count - popped + pushed. A released index is not allocatable until the next cycle (no bypass).
- Checkpoint:
  - ckpt_take stores head_next (including this cycle's allocation) and clears the allocs-since-checkpoint counter.
  - Every later successful allocation adds n to that counter.
- Restore:
  - ckpt_restore sets head to the snapshot, adds the counter back to count, and clears the counter. Releases in the same cycle are still applied.
  - ckpt_take and ckpt_restore in the same cycle: restore wins, then the snapshot equals the restored head.
- free_count = count; it reflects registered state.

## Timing
- alloc_ok and alloc_addrs are combinational from alloc_req, ckpt_restore and the registered head/count. There is zero-cycle latency to the rename stage.
- All state updates happen on posedge clk. rst forces the reset state immediately, independent of clk.
- Reset values: free_count=30-ARCH_REGS, overflow_err=0. alloc_ok=1 when alloc_req=0; alloc_addrs lane0=2+ARCH_REGS.
- Wrap-around: head/tail increment mod 30 (29 -> 0). Multi-lane pops and pushes may straddle the wrap.
- Empty: count=0 gives alloc_ok=0 for any nonzero request. A release that cycle makes the index available next cycle.

## Structure
- Shared header constants: PREG_W=5, PHYS_REGS=32, FREE_DEPTH=30, PREG_ZERO=0, PREG_ONE=1. The physical register file uses the same constants.
- One sub-module, ring_idx_add: (index + offset) mod 30, combinational. It is used for head, tail and per-lane offsets.
- Lane compaction is a prefix popcount inside the top level.

## Test plan
- Reset, no requests: free_count=24, alloc_ok=1, alloc_addrs lane0=8.
- alloc_req=2'b11: lanes get 8 and 9. Next cycle alloc_req=2'b10: lane1 gets 10 and free_count=21.
- Drain to count=1, then alloc_req=2'b11: alloc_ok=0 and free_count stays 1. The same cycle, free_valid=2'b01 with addr 9: next cycle free_count=2 and alloc_req=2'b11 succeeds, returning the last entry and 9.
- free_valid=2'b11 with addrs 0 and 1: no change to free_count or tail.
- ckpt_take at head=0, then three single allocs (8, 9, 10), then ckpt_restore: free_count back to 24 and next alloc returns 8. alloc_req during the restore cycle gives alloc_ok=0.
- Fill to 30 through releases, then release one more: free_count stays 30 and overflow_err=1 until rst. Assert rst mid-cycle: all state returns to reset values without a clock edge.
